// File: rtl/mux_pkg.sv
// Shared constants and helpers for the scan_mux family: state encodings and
// the width helpers used to size the select and dwell counters.
package mux_pkg;

  localparam logic [1:0] MAN    = 2'd0;
  localparam logic [1:0] SCAN   = 2'd1;
  localparam logic [1:0] FROZEN = 2'd2;

  // Ceiling log2, evaluated at elaboration time for sizing registers.
  function automatic int clog2(input int value);
    int result;
    int remain;
    result = 0;
    remain = value - 1;
    for (int i = 0; i < 32; i++) begin
      if (remain > 0) begin
        result = result + 1;
        remain = remain >> 1;
      end
    end
    return result;
  endfunction

  // Register width for a range of `value` entries; never narrower than 1 bit.
  function automatic int width_of(input int value);
    return (clog2(value) < 1) ? 1 : clog2(value);
  endfunction

endpackage

// File: rtl/mux_slice.sv
// Combinational N:1 selector returning the W-bit slice of data_in picked by ch.
// Unused select codes (N not a power of two) return zero.
module mux_slice
  import mux_pkg::*;
#(
  parameter  int N       = 4,
  parameter  int W       = 1,
  localparam int SW_BITS = width_of(N)
) (
  input  logic [N*W-1:0]   data_in,
  input  logic [SW_BITS-1:0] ch,
  output logic [W-1:0]     slice
);

  // Walk every channel and keep the one whose index matches ch.
  always_comb begin
    slice = '0;
    for (int k = 0; k < N; k++) begin
      if (ch == SW_BITS'(k)) begin
        slice = data_in[k*W +: W];
      end
    end
  end

endmodule

// File: rtl/scan_mux.sv
// Registered N-channel W-bit multiplexer with manual select, an auto-scan
// sequencer with programmable dwell, and a hold input that freezes everything.
// The behaviour of each edge is decided by the state being entered on that
// edge, so hold suppresses a step scheduled for the very edge it is seen on.
module scan_mux
  import mux_pkg::*;
#(
  parameter  int N       = 4,
  parameter  int W       = 1,
  parameter  int DWELL   = 4,
  localparam int SW_BITS = width_of(N)
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic [N*W-1:0]     data_in,
  input  logic [SW_BITS-1:0] sel,
  input  logic               mode,
  input  logic               hold,
  output logic [W-1:0]       out_data,
  output logic [SW_BITS-1:0] out_ch,
  output logic               out_change,
  output logic               out_wrap
);

  localparam int CNT_BITS = width_of(DWELL);
  localparam logic [SW_BITS-1:0]  LAST_CH  = SW_BITS'(N - 1);
  localparam logic [SW_BITS:0]    N_EXT    = (SW_BITS + 1)'(N);
  localparam logic [CNT_BITS-1:0] LAST_CNT = CNT_BITS'(DWELL - 1);

  logic [1:0]          state_q, state_d;
  logic [SW_BITS-1:0]  ch_q, ch_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic [CNT_BITS-1:0] cnt_base;
  logic [W-1:0]        data_q, data_d;
  logic                change_q, change_d;
  logic                wrap_q, wrap_d;
  logic [SW_BITS-1:0]  sel_clamped;
  logic [W-1:0]        next_slice;

  // Out-of-range manual selects collapse onto the last real channel.
  always_comb begin
    sel_clamped = ({1'b0, sel} >= N_EXT) ? LAST_CH : sel;
  end

  // Next state, channel pointer, dwell counter and wrap pulse.
  always_comb begin
    state_d  = hold ? FROZEN : (mode ? SCAN : MAN);
    ch_d     = ch_q;
    cnt_d    = cnt_q;
    wrap_d   = 1'b0;
    cnt_base = (state_q == MAN) ? '0 : cnt_q;
    case (state_d)
      MAN: begin
        ch_d  = sel_clamped;
        cnt_d = '0;
      end
      SCAN: begin
        if (cnt_base == LAST_CNT) begin
          cnt_d = '0;
          if (ch_q == LAST_CH) begin
            ch_d   = '0;
            wrap_d = 1'b1;
          end else begin
            ch_d = ch_q + SW_BITS'(1);
          end
        end else begin
          cnt_d = cnt_base + CNT_BITS'(1);
        end
      end
      default: begin
      end
    endcase
  end

  mux_slice #(
    .N (N),
    .W (W)
  ) u_slice (
    .data_in (data_in),
    .ch      (ch_d),
    .slice   (next_slice)
  );

  // Output data follows the next channel unless frozen; change pulses on a move.
  always_comb begin
    data_d   = (state_d == FROZEN) ? data_q : next_slice;
    change_d = (ch_d != ch_q);
  end

  // State and output registers, cleared immediately by resetn.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= MAN;
      ch_q     <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
      change_q <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      change_q <= change_d;
      wrap_q   <= wrap_d;
    end
  end

  assign out_data   = data_q;
  assign out_ch     = ch_q;
  assign out_change = change_q;
  assign out_wrap   = wrap_q;

endmodule

// File: tb/tb_scan_mux.sv
// Scoreboard bench for scan_mux: dutA (N=4, W=4, DWELL=3) covers manual,
// auto-scan, hold and reset; dutB (N=3, W=2) covers select clamping.
module tb_scan_mux;

  typedef struct {
    int         cyc;
    int         dut;
    int         tag;
    logic [3:0] data;
    logic [1:0] ch;
    logic       chg;
    logic       wrap;
  } exp_t;

  logic        clock = 1'b0;
  logic        resetn;
  logic [15:0] dataA;
  logic [5:0]  dataB;
  logic [1:0]  selA, selB;
  logic        mode, hold;
  logic [3:0]  aData;
  logic [1:0]  aCh;
  logic        aChg, aWrap;
  logic [1:0]  bData;
  logic [1:0]  bCh;
  logic        bChg, bWrap;

  exp_t sbq[$];
  int   cyc = 0;
  int   tagCount = 0;
  int   checks = 0;
  int   failures = 0;

  scan_mux #(.N(4), .W(4), .DWELL(3)) dutA (
    .clock (clock), .resetn (resetn), .data_in (dataA), .sel (selA),
    .mode (mode), .hold (hold), .out_data (aData), .out_ch (aCh),
    .out_change (aChg), .out_wrap (aWrap)
  );

  scan_mux #(.N(3), .W(2), .DWELL(2)) dutB (
    .clock (clock), .resetn (resetn), .data_in (dataB), .sel (selB),
    .mode (mode), .hold (hold), .out_data (bData), .out_ch (bCh),
    .out_change (bChg), .out_wrap (bWrap)
  );

  always #5 clock = ~clock;

  // Compare one DUT's outputs against an expected tuple.
  task automatic checkOutput(input int dut, input int tag, input logic [3:0] d,
                             input logic [1:0] ch, input logic chg, input logic wrap);
    logic [7:0] act, req;
    req = {d, ch, chg, wrap};
    act = (dut == 0) ? {aData, aCh, aChg, aWrap} : {2'b00, bData, bCh, bChg, bWrap};
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL check%0d dut%0d cyc=%0d got data=%h ch=%0d chg=%b wrap=%b want data=%h ch=%0d chg=%b wrap=%b",
               tag, dut, cyc, act[7:4], act[3:2], act[1], act[0], req[7:4], req[3:2], req[1], req[0]);
    end
  endtask

  // Queue the response expected after the next rising edge.
  task automatic expectOut(input int dut, input logic [3:0] d, input logic [1:0] ch,
                           input logic chg, input logic wrap);
    exp_t e;
    e.cyc = cyc + 1; e.dut = dut; e.tag = tagCount; e.data = d;
    e.ch = ch; e.chg = chg; e.wrap = wrap;
    tagCount++;
    sbq.push_back(e);
  endtask

  task automatic applyStimulus(input logic [1:0] sa, input logic [1:0] sb,
                               input logic m, input logic h);
    selA = sa; selB = sb; mode = m; hold = h;
  endtask

  // Monitor: just after each edge, pop and compare everything due this cycle.
  always @(posedge clock) begin
    #1;
    cyc++;
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      exp_t e;
      e = sbq.pop_front();
      checkOutput(e.dut, e.tag, e.data, e.ch, e.chg, e.wrap);
    end
  end

  logic [1:0] scanCh  [12] = '{0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
  logic       scanChg [12] = '{0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 1};
  logic [3:0] sliceA  [4]  = '{4'hA, 4'hB, 4'hC, 4'hD};
  logic [1:0] moreCh  [4]  = '{0, 0, 1, 1};
  logic       moreChg [4]  = '{0, 0, 1, 0};

  initial begin
    resetn = 1'b0;
    dataA  = 16'hDCBA;
    dataB  = 6'b111001;
    applyStimulus(2'd2, 2'd3, 1'b0, 1'b0);

    // Reset held with live data: everything zero, including after release.
    @(negedge clock); #1;
    checkOutput(0, 900, 4'h0, 2'd0, 1'b0, 1'b0);
    checkOutput(1, 901, 4'h0, 2'd0, 1'b0, 1'b0);
    resetn = 1'b1; #1;
    checkOutput(0, 902, 4'h0, 2'd0, 1'b0, 1'b0);
    checkOutput(1, 903, 4'h0, 2'd0, 1'b0, 1'b0);

    // Manual select, plus clamp of sel=3 on the 3-channel instance.
    expectOut(0, 4'hC, 2'd2, 1'b1, 1'b0);
    expectOut(1, 4'h3, 2'd2, 1'b1, 1'b0);
    @(negedge clock);
    applyStimulus(2'd3, 2'd3, 1'b0, 1'b0);
    dataB = 6'b100100;
    expectOut(0, 4'hD, 2'd3, 1'b1, 1'b0);
    expectOut(1, 4'h2, 2'd2, 1'b0, 1'b0);
    @(negedge clock);
    applyStimulus(2'd0, 2'd3, 1'b0, 1'b0);
    expectOut(0, 4'hA, 2'd0, 1'b1, 1'b0);
    @(negedge clock);

    // Full auto-scan sweep from channel 0 with wrap on the twelfth edge.
    applyStimulus(2'd0, 2'd3, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) begin
      expectOut(0, sliceA[scanCh[i]], scanCh[i], scanChg[i], (i == 11));
      @(negedge clock);
    end
    for (int i = 0; i < 4; i++) begin
      expectOut(0, sliceA[moreCh[i]], moreCh[i], moreChg[i], 1'b0);
      @(negedge clock);
    end

    // Hold with cnt=1 on channel 1; data changes must not leak through.
    applyStimulus(2'd0, 2'd3, 1'b1, 1'b1);
    dataA = 16'h1234;
    for (int i = 0; i < 5; i++) begin
      expectOut(0, 4'hB, 2'd1, 1'b0, 1'b0);
      @(negedge clock);
    end
    applyStimulus(2'd0, 2'd3, 1'b1, 1'b0);
    expectOut(0, 4'h3, 2'd1, 1'b0, 1'b0);
    @(negedge clock);
    expectOut(0, 4'h2, 2'd2, 1'b1, 1'b0);
    @(negedge clock);
    expectOut(0, 4'h2, 2'd2, 1'b0, 1'b0);
    @(negedge clock);
    expectOut(0, 4'h2, 2'd2, 1'b0, 1'b0);
    @(negedge clock);
    expectOut(0, 4'h1, 2'd3, 1'b1, 1'b0);
    @(negedge clock);

    // Asynchronous reset between edges while showing channel 3.
    #1 resetn = 1'b0;
    #1;
    checkOutput(0, 904, 4'h0, 2'd0, 1'b0, 1'b0);
    checkOutput(1, 905, 4'h0, 2'd0, 1'b0, 1'b0);
    applyStimulus(2'd2, 2'd3, 1'b0, 1'b0);
    #1 resetn = 1'b1;
    expectOut(0, 4'h2, 2'd2, 1'b1, 1'b0);
    expectOut(1, 4'h2, 2'd2, 1'b1, 1'b0);
    @(negedge clock);
    applyStimulus(2'd3, 2'd3, 1'b0, 1'b0);
    expectOut(0, 4'h1, 2'd3, 1'b1, 1'b0);
    @(negedge clock);
    expectOut(0, 4'h1, 2'd3, 1'b0, 1'b0);
    @(negedge clock);
    @(negedge clock);

    // Anything still queued was never compared.
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain got %0d pending want 0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
